// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end:
// NOP encoding, fetch FSM states, default vector addresses.
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR     = 16'h0000;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_INT_VEC   = 32'h0000_0002;

    typedef enum logic [2:0] {
        ST_VEC_HI = 3'd0,
        ST_VEC_LO = 3'd1,
        ST_FETCH  = 3'd2,
        ST_INT_HI = 3'd3,
        ST_INT_LO = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_int_latch.sv
// Interrupt request latch: samples the level input, detects
// a rising edge and holds a pending flag until cleared.
module fetch_int_latch (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_interrupt,
    input  logic i_clear,
    output logic o_pending
);

    logic samp_q;
    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise = samp_q & ~prev_q;

    // A new edge wins over a clear in the same cycle
    always_comb begin
        pend_d = pend_q;
        if (i_clear) pend_d = 1'b0;
        if (rise)    pend_d = 1'b1;
    end

    // Sample the request and keep the previous sample for edge detect
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            samp_q <= 1'b0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            samp_q <= i_interrupt;
            prev_q <= samp_q;
            pend_q <= pend_d;
        end
    end

    assign o_pending = pend_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC owner, 16-bit instruction fetch, vector loads.
// Optional interrupt tokens when FETCH_INT_EN is defined.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VEC_ADDR = PC_WIDTH'(DEF_RESET_VEC),
    parameter logic [PC_WIDTH-1:0] INT_VEC_ADDR   = PC_WIDTH'(DEF_INT_VEC)
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_stall,
    input  logic                   i_redirect,
    input  logic [PC_WIDTH-1:0]    i_redirect_pc,
    input  logic                   i_interrupt,
    output logic                   o_imem_req,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    input  logic                   i_imem_valid,
    output logic                   o_valid,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_interrupt
);

    localparam int H = PC_WIDTH / 2;

    fetch_state_e state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    logic                   outst_q;
    logic                   disc_q;
    logic [PC_WIDTH-1:0]    raddr_q;

    logic                   valid_q;
    logic [PC_WIDTH-1:0]    opc_q;
    logic [INSTR_WIDTH-1:0] instr_q;

    logic                   want;
    logic [PC_WIDTH-1:0]    iaddr;
    logic                   issue;
    logic                   resp;
    logic                   keep;
    logic                   redir;
    logic                   slot_free;
    logic                   pending;
    logic                   int_take;
    logic                   clr;

    assign redir = i_redirect
                 & (state_q != ST_VEC_HI)
                 & (state_q != ST_VEC_LO);

    assign slot_free = ~valid_q | ~i_stall;

`ifdef FETCH_INT_EN
    fetch_int_latch u_int (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_interrupt (i_interrupt),
        .i_clear     (clr),
        .o_pending   (pending)
    );
`else
    logic int_unused;
    assign int_unused = i_interrupt | clr;
    assign pending    = 1'b0;
`endif

    assign issue    = i_reset_n & ~outst_q & want & ~redir;
    assign resp     = i_imem_valid & (outst_q | issue);
    assign keep     = resp & ~(outst_q & disc_q) & ~redir;
    assign int_take = (state_q == ST_FETCH) & pending
                    & ~outst_q & slot_free & ~redir;

    // State and PC register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_VEC_HI;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state: vector halves, sequential fetch, redirect
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        clr     = 1'b0;
        if (redir) begin
            state_d = ST_FETCH;
            pc_d    = i_redirect_pc;
        end else begin
            unique case (state_q)
                ST_VEC_HI: if (keep) begin
                    pc_d    = {i_imem_rdata, pc_q[H-1:0]};
                    state_d = ST_VEC_LO;
                end
                ST_VEC_LO: if (keep) begin
                    pc_d    = {pc_q[PC_WIDTH-1:H], i_imem_rdata};
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (keep)          pc_d    = pc_q + PC_WIDTH'(1);
                    else if (int_take) state_d = ST_INT_HI;
                end
`ifdef FETCH_INT_EN
                ST_INT_HI: if (keep) begin
                    pc_d    = {i_imem_rdata, pc_q[H-1:0]};
                    state_d = ST_INT_LO;
                end
                ST_INT_LO: if (keep) begin
                    pc_d    = {pc_q[PC_WIDTH-1:H], i_imem_rdata};
                    state_d = ST_FETCH;
                    clr     = 1'b1;
                end
`endif
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // Request decode: what to read in the current state
    always_comb begin
        want  = 1'b0;
        iaddr = pc_q;
        unique case (state_q)
            ST_VEC_HI: begin
                want  = 1'b1;
                iaddr = RESET_VEC_ADDR;
            end
            ST_VEC_LO: begin
                want  = 1'b1;
                iaddr = RESET_VEC_ADDR + PC_WIDTH'(1);
            end
            ST_FETCH: want = slot_free & ~pending;
            ST_INT_HI: begin
                want  = 1'b1;
                iaddr = INT_VEC_ADDR;
            end
            ST_INT_LO: begin
                want  = 1'b1;
                iaddr = INT_VEC_ADDR + PC_WIDTH'(1);
            end
            default: want = 1'b0;
        endcase
    end

    // Outstanding request tracking; redirect marks it stale
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            outst_q <= 1'b0;
            disc_q  <= 1'b0;
            raddr_q <= '0;
        end else if (resp) begin
            outst_q <= 1'b0;
            disc_q  <= 1'b0;
        end else begin
            if (issue) begin
                outst_q <= 1'b1;
                raddr_q <= iaddr;
            end
            if (redir & outst_q) disc_q <= 1'b1;
        end
    end

    assign o_imem_req  = outst_q | issue;
    assign o_imem_addr = outst_q ? raddr_q
                       : (issue ? iaddr : '0);

    // Output slot: fill from memory, hold on stall, drop on redirect
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            opc_q   <= '0;
            instr_q <= '0;
        end else if (redir) begin
            valid_q <= 1'b0;
        end else if ((state_q == ST_FETCH) && keep) begin
            valid_q <= 1'b1;
            opc_q   <= pc_q;
            instr_q <= i_imem_rdata;
        end else if (int_take) begin
            valid_q <= 1'b1;
            opc_q   <= pc_q;
            instr_q <= NOP_INSTR;
        end else if (valid_q && !i_stall) begin
            valid_q <= 1'b0;
        end
    end

`ifdef FETCH_INT_EN
    logic oint_q;

    // Tag the slot as an interrupt token
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            oint_q <= 1'b0;
        else if (redir)
            oint_q <= 1'b0;
        else if ((state_q == ST_FETCH) && keep)
            oint_q <= 1'b0;
        else if (int_take)
            oint_q <= 1'b1;
    end

    assign o_interrupt = valid_q & oint_q;
`else
    assign o_interrupt = 1'b0;
`endif

    assign o_valid = valid_q;
    assign o_pc    = opc_q;
    assign o_instr = (valid_q && !o_interrupt) ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus a
// randomized phase checked against a program-order token model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        intr;
    logic        req;
    logic [31:0] addr;
    logic [15:0] rdata;
    logic        mvalid;
    logic        valid;
    logic [31:0] pc;
    logic [15:0] instr;
    logic        ointr;

    int checks = 0;
    int errors = 0;

    int lat = 0;
    bit rand_lat = 1'b0;
    int cnt;
    logic [15:0] vec [4];

    always #5 clk = ~clk;

    fetch_unit dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_stall       (stall),
        .i_redirect    (redir),
        .i_redirect_pc (rpc),
        .i_interrupt   (intr),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_rdata  (rdata),
        .i_imem_valid  (mvalid),
        .o_valid       (valid),
        .o_pc          (pc),
        .o_instr       (instr),
        .o_interrupt   (ointr)
    );

    function automatic logic [15:0] memf(input logic [31:0] a);
        if (a < 32'd4) return vec[a[1:0]];
        return a[15:0] ^ a[31:16] ^ 16'h5A5A;
    endfunction

    always_comb rdata = memf(addr);
    assign mvalid = req && (cnt >= lat);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
        end else if (req && mvalid) begin
            cnt <= 0;
            if (rand_lat) lat <= int'($urandom_range(0, 2));
        end else if (req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (valid !== 1'b1 && n < max) begin
            cyc();
            n++;
        end
        chk("wait_valid", 32'(valid), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_pc;
        int consumed;
        bit rd;
        logic [31:0] tgt;

        rst_n = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        rpc   = '0;
        intr  = 1'b0;
        vec[0] = 16'h0000;
        vec[1] = 16'h0010;
        vec[2] = 16'h0000;
        vec[3] = 16'h0100;

        // reset state
        repeat (2) cyc();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc",    pc,         32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_int",   32'(ointr), 32'd0);
        chk("rst_req",   32'(req),   32'd0);
        chk("rst_addr",  addr,       32'd0);

        // reset vector load
        rst_n = 1'b1;
        #1;
        chk("vec_hi_req",  32'(req), 32'd1);
        chk("vec_hi_addr", addr,     32'd0);
        cyc();
        chk("vec_lo_addr", addr,     32'd1);
        cyc();
        chk("first_addr",  addr,     32'h10);
        chk("first_nov",   32'(valid), 32'd0);
        cyc();
        chk("tok0_v",  32'(valid), 32'd1);
        chk("tok0_pc", pc,         32'h10);
        chk("tok0_in", 32'(instr), 32'(memf(32'h10)));
        cyc();
        chk("tok1_pc", pc,         32'h11);

        // stall holds slot, no request
        stall = 1'b1;
        #1;
        chk("stall_noreq", 32'(req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", pc,         32'h11);
            chk("stall_in", 32'(instr), 32'(memf(32'h11)));
            chk("stall_nr", 32'(req),   32'd0);
        end
        stall = 1'b0;
        #1;
        chk("resume_addr", addr, 32'h12);
        cyc();
        chk("resume_pc", pc, 32'h12);

        // 2-cycle memory, redirect while waiting
        lat = 2;
        #1;
        chk("lat_addr", addr, 32'h13);
        cyc();
        redir = 1'b1;
        rpc   = 32'h40;
        #1;
        chk("wait_req",  32'(req), 32'd1);
        chk("wait_addr", addr,     32'h13);
        cyc();
        redir = 1'b0;
        #1;
        chk("drop_nov",  32'(valid), 32'd0);
        chk("drop_addr", addr,       32'h13);
        cyc();
        chk("redir_addr", addr, 32'h40);
        wait_valid(10);
        chk("redir_pc", pc,         32'h40);
        chk("redir_in", 32'(instr), 32'(memf(32'h40)));
        lat = 0;

        // interrupt raised while 0x1F sits stalled in the slot
        redir = 1'b1;
        rpc   = 32'h1F;
        cyc();
        redir = 1'b0;
        wait_valid(10);
        chk("pre_int_pc", pc, 32'h1F);
        stall = 1'b1;
        intr  = 1'b1;
        cyc();
        intr = 1'b0;
        repeat (3) cyc();
        chk("int_hold_pc", pc, 32'h1F);
        stall = 1'b0;
        cyc();
`ifdef FETCH_INT_EN
        chk("int_v",   32'(valid), 32'd1);
        chk("int_tok", 32'(ointr), 32'd1);
        chk("int_pc",  pc,         32'h20);
        chk("int_in",  32'(instr), 32'd0);
        cyc();
        wait_valid(10);
        chk("isr_pc",  pc,         32'h100);
        chk("isr_int", 32'(ointr), 32'd0);
        chk("isr_in",  32'(instr), 32'(memf(32'h100)));
`else
        chk("noint_v",  32'(valid), 32'd1);
        chk("noint_f",  32'(ointr), 32'd0);
        chk("noint_pc", pc,         32'h20);
        chk("noint_in", 32'(instr), 32'(memf(32'h20)));
        cyc();
        chk("noint_nx", pc,         32'h21);
`endif

        // PC wraps from all-ones to zero
        redir = 1'b1;
        rpc   = 32'hFFFF_FFFF;
        cyc();
        redir = 1'b0;
        wait_valid(10);
        chk("wrap_pc",   pc,        32'hFFFF_FFFF);
        chk("wrap_req",  32'(req),  32'd1);
        chk("wrap_addr", addr,      32'h0);
        cyc();
        chk("wrap_nx",   pc,        32'h0);

        // random stalls, latencies and redirects vs program order
        rand_lat = 1'b1;
        redir    = 1'b1;
        rpc      = 32'h3000;
        exp_pc   = 32'h3000;
        cyc();
        redir    = 1'b0;
        consumed = 0;
        for (int i = 0; i < 600; i++) begin
            if (valid) begin
                chk("rnd_pc", pc,         exp_pc);
                chk("rnd_in", 32'(instr), 32'(memf(exp_pc)));
            end
            stall = ($urandom_range(0, 2) == 0);
            rd    = ($urandom_range(0, 49) == 0);
            tgt   = 32'h3000 + 32'($urandom_range(0, 255));
            redir = rd;
            rpc   = tgt;
            if (rd) begin
                exp_pc = tgt;
            end else if (valid && !stall) begin
                exp_pc = exp_pc + 32'd1;
                consumed++;
            end
            cyc();
        end
        redir = 1'b0;
        stall = 1'b0;
        chk("rnd_progress", 32'(consumed > 100), 32'd1);

        // reset mid-flight drops everything
        rand_lat = 1'b0;
        lat      = 2;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", 32'(valid), 32'd0);
        chk("rst2_req",   32'(req),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage: owns the PC, fetches 16-bit instructions from the instruction memory over a request/valid handshake, and produces the `pc`/`instr`/`interrupt` triple consumed by the fetch/decode pipeline buffer. It loads the start PC from a reset vector, follows branch redirects, honours downstream stalls, and injects interrupt tokens before jumping through the interrupt vector. One outstanding memory request at most; one instruction per cycle with a zero-wait memory.

## Interface
- `PC_WIDTH`, 32, PC and memory address width; addresses are halfword-granular.
- `INSTR_WIDTH`, 16, instruction width.
- `RESET_VEC_ADDR`, 0, address of the 2-halfword reset vector.
- `INT_VEC_ADDR`, 2, address of the 2-halfword interrupt vector.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_stall`  in  1  downstream buffer not accepting this cycle.
- `i_redirect`  in  1  branch/jump taken; squash and refetch.
- `i_redirect_pc`  in  32  redirect target.
- `i_interrupt`  in  1  external interrupt request, level, sampled.
- `o_imem_req`  out  1  memory read request.
- `o_imem_addr`  out  32  memory read address.
- `i_imem_rdata`  in  16  memory read data.
- `i_imem_valid`  in  1  read data valid; may arrive in the request cycle or later.
- `o_valid`  out  1  output slot holds a token.
- `o_pc`  out  32  PC of token (interrupt token: return PC).
- `o_instr`  out  16  instruction; 16'h0000 (NOP) when `o_valid`=0 or interrupt token.
- `o_interrupt`  out  1  token is an interrupt token.

## Operation
- States: VEC_HI, VEC_LO, FETCH, INT_HI, INT_LO.
- VEC_HI/VEC_LO: read `RESET_VEC_ADDR` (PC[31:16]) then `+1` (PC[15:0]); then FETCH. INT_HI/INT_LO identical using `INT_VEC_ADDR`.
- FETCH: issue request at PC when no request outstanding and slot free (`o_valid`=0 or consumed this cycle); on `i_imem_valid` capture `{pc, rdata}` into slot, `o_valid`<=1, PC<=PC+1 (mod 2^32, 0xFFFFFFFF wraps to 0).
- Slot consumed when `o_valid`=1 and `i_stall`=0; held unchanged while stalled.
- `o_imem_req`/`o_imem_addr` held stable from issue until `i_imem_valid`; `i_imem_valid` without outstanding request ignored.
- Redirect (any state except VEC_*): PC<=`i_redirect_pc`, `o_valid`<=0, outstanding response marked discard; state FETCH. Wins over stall, memory valid and interrupt in the same cycle.
- Interrupt: rising edge of sampled `i_interrupt` sets `pending`. In FETCH with `pending`, no request outstanding and slot free: emit token (`o_valid`=1, `o_interrupt`=1, `o_instr`=NOP, `o_pc`=PC), go INT_HI. `pending` cleared only when INT_LO completes; redirect during INT_* aborts to FETCH, `pending` stays set and is retaken.
- Redirect in VEC_* ignored.

## Timing
- Reset values: `o_valid`=0, `o_pc`=0, `o_instr`=0, `o_interrupt`=0, `o_imem_req`=0, `o_imem_addr`=0, PC=0, `pending`=0, state VEC_HI. Reset mid-request drops it; memory is reset alongside.
- First cycle after release: `o_imem_req`=1, addr=`RESET_VEC_ADDR`.
- Latency: data valid in cycle N appears on outputs in cycle N+1.
- Zero-wait memory, no stall: one token per cycle; vector load costs 2 cycles.
- Discarded response: consumed, no slot write, next request issued next cycle.

## Configuration
- `FETCH_INT_EN` defined: interrupt latch, INT_* states and `o_interrupt` generation present.
- Undefined: `i_interrupt` ignored, `o_interrupt` tied 0, no INT_* states; all else identical.

## Structure
- Shared package `cpu_pkg`: `NOP_INSTR`, fetch state encoding, default vector addresses.
- One sub-module: `fetch_int_latch` (sampling, edge detect, pending set/clear).

## Test plan
- Reset, mem M[0]=0x0000, M[1]=0x0010 -> first fetch addr 0x10; tokens pc 0x10,0x11,0x12 on consecutive cycles.
- `i_stall`=1 for 3 cycles with pc 0x11 in slot -> `o_pc`/`o_instr` held, no new request; resumes 0x12 next cycle.
- 2-cycle memory latency, redirect to 0x40 mid-wait -> stale response dropped, next token pc 0x40.
- Interrupt pulse at pc 0x20, M[2..3]=0x0000_0100 -> token `o_interrupt`=1, `o_pc`=0x20, `o_instr`=0; next token pc 0x100.
- PC 0xFFFFFFFF fetched -> next request addr 0x00000000.
- `FETCH_INT_EN` undefined, pulse `i_interrupt` -> no token, fetch continues uninterrupted.
